// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the alu_arbiter block: FSM encoding, ALU op codes
// and the default response-wait limit.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOT = 3'b101;
  localparam logic [2:0] ALU_SHL = 3'b110;
  localparam logic [2:0] ALU_SHR = 3'b111;

  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the requesting front-ends (master) and alu_arbiter (slave).
// The timeout_err signal exists only when ALU_ARB_TIMEOUT_EN is defined.
interface alu_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [3*NREQ-1:0] req_op;
  logic [4*NREQ-1:0] req_a;
  logic [4*NREQ-1:0] req_b;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [3:0]        rsp_res;
  logic [2:0]        rsp_flags;
  logic [1:0]        grant_id;
  logic              busy;
`ifdef ALU_ARB_TIMEOUT_EN
  logic              timeout_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_res, rsp_flags, grant_id, busy, timeout_err
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_res, rsp_flags, grant_id, busy, timeout_err
  );
`else
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_res, rsp_flags, grant_id, busy
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_res, rsp_flags, grant_id, busy
  );
`endif
endinterface

// File: rtl/alu_4bit.sv
// Combinational 4-bit ALU: result plus carry, signed-overflow and zero flags.
// For SUB the carry is the carry-out of a + ~b + 1 (1 means no borrow).
module alu_4bit
  import alu_arb_pkg::*;
(
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic [2:0] i_alu_fnselec,
  output logic [3:0] o_res,
  output logic       o_carry,
  output logic       o_overflow,
  output logic       o_zero
);

  logic [4:0] w_sum;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    w_sum      = '0;
    o_res      = '0;
    o_carry    = 1'b0;
    o_overflow = 1'b0;
    case (i_alu_fnselec)
      ALU_ADD: begin
        w_sum      = {1'b0, i_a} + {1'b0, i_b};
        o_res      = w_sum[3:0];
        o_carry    = w_sum[4];
        o_overflow = (i_a[3] == i_b[3]) && (w_sum[3] != i_a[3]);
      end
      ALU_SUB: begin
        w_sum      = {1'b0, i_a} + {1'b0, ~i_b} + 5'd1;
        o_res      = w_sum[3:0];
        o_carry    = w_sum[4];
        o_overflow = (i_a[3] != i_b[3]) && (w_sum[3] != i_a[3]);
      end
      ALU_AND: o_res = i_a & i_b;
      ALU_OR:  o_res = i_a | i_b;
      ALU_XOR: o_res = i_a ^ i_b;
      ALU_NOT: o_res = ~i_a;
      ALU_SHL: begin
        o_res   = {i_a[2:0], 1'b0};
        o_carry = i_a[3];
      end
      ALU_SHR: begin
        o_res   = {1'b0, i_a[3:1]};
        o_carry = i_a[0];
      end
      default: o_res = '0;
    endcase
  end

  assign o_zero = (o_res == 4'd0);

endmodule

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational round-robin picker: one-hot select of the first valid requester
// searching upward from last_grant+1 and wrapping to 0.
module rr_picker #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] i_req_valid,
  input  logic [1:0]      i_last_grant,
  output logic [NREQ-1:0] o_pick,
  output logic [1:0]      o_pick_id,
  output logic            o_any
);

  logic w_found;

  // First pass covers indices above last_grant, second pass the wrapped-around ones.
  always_comb begin
    o_pick    = '0;
    o_pick_id = '0;
    w_found   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && i_req_valid[i] && (i > int'(i_last_grant))) begin
        w_found   = 1'b1;
        o_pick[i] = 1'b1;
        o_pick_id = 2'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && i_req_valid[i]) begin
        w_found   = 1'b1;
        o_pick[i] = 1'b1;
        o_pick_id = 2'(i);
      end
    end
  end

  assign o_any = |i_req_valid;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one alu_4bit among NREQ requesters, one op in flight.
// Define ALU_ARB_TIMEOUT_EN to add the RESP wait limit (TIMEOUT cycles) and the sticky timeout_err.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);

  if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
    $error("alu_arbiter: NREQ must be in 2..4");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("alu_arbiter: TIMEOUT must be in 1..255");
  end

  state_t          r_state;
  state_t          w_next_state;
  logic [1:0]      r_last_grant;
  logic [1:0]      r_grant_id;
  logic [NREQ-1:0] r_grant_oh;
  logic [2:0]      r_op;
  logic [3:0]      r_a;
  logic [3:0]      r_b;
  logic [3:0]      r_res;
  logic [2:0]      r_flags;
  logic [NREQ-1:0] r_rsp_valid;
  logic            r_busy;

  logic [NREQ-1:0] w_pick;
  logic [1:0]      w_pick_id;
  logic            w_any;
  logic [NREQ-1:0] w_req_ready;
  logic            w_accept;
  logic            w_rsp_done;
  logic            w_rsp_ready_g;
  logic [2:0]      w_sel_op;
  logic [3:0]      w_sel_a;
  logic [3:0]      w_sel_b;
  logic [3:0]      w_alu_res;
  logic            w_alu_carry;
  logic            w_alu_ovf;
  logic            w_alu_zero;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .i_req_valid  (bus.req_valid),
    .i_last_grant (r_last_grant),
    .o_pick       (w_pick),
    .o_pick_id    (w_pick_id),
    .o_any        (w_any)
  );

  alu_4bit u_alu (
    .i_a           (r_a),
    .i_b           (r_b),
    .i_alu_fnselec (r_op),
    .o_res         (w_alu_res),
    .o_carry       (w_alu_carry),
    .o_overflow    (w_alu_ovf),
    .o_zero        (w_alu_zero)
  );

  always_comb begin
    w_sel_op = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick[i]) begin
        w_sel_op = bus.req_op[3*i +: 3];
        w_sel_a  = bus.req_a[4*i +: 4];
        w_sel_b  = bus.req_b[4*i +: 4];
      end
    end
  end

  // Only the granted requester's rsp_ready can complete the response.
  assign w_rsp_ready_g = |(bus.rsp_ready & r_grant_oh);

`ifdef ALU_ARB_TIMEOUT_EN
  logic [7:0] r_wait_cnt;
  logic       r_timeout_err;
  logic       w_timeout_hit;

  assign w_timeout_hit = (r_state == ST_RESP) && !w_rsp_ready_g &&
                         (r_wait_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state != ST_RESP || w_rsp_done) r_wait_cnt <= '0;
      else                                  r_wait_cnt <= r_wait_cnt + 8'd1;
      if (w_timeout_hit) r_timeout_err <= 1'b1;
    end
  end

  assign bus.timeout_err = r_timeout_err;
`endif

  always_comb begin
    w_next_state = r_state;
    w_req_ready  = '0;
    w_accept     = 1'b0;
    w_rsp_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_req_ready  = w_pick;
          w_accept     = 1'b1;
          w_next_state = ST_EXEC;
        end
      end
      ST_EXEC: w_next_state = ST_RESP;
      ST_RESP: begin
        if (w_rsp_ready_g) w_rsp_done = 1'b1;
`ifdef ALU_ARB_TIMEOUT_EN
        if (w_timeout_hit) w_rsp_done = 1'b1;
`endif
        if (w_rsp_done) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 2'(NREQ - 1);
      r_grant_id   <= '0;
      r_grant_oh   <= '0;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_res        <= '0;
      r_flags      <= '0;
      r_rsp_valid  <= '0;
      r_busy       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state <= w_next_state;
      r_busy  <= (w_next_state != ST_IDLE);
      if (w_accept) begin
        r_op       <= w_sel_op;
        r_a        <= w_sel_a;
        r_b        <= w_sel_b;
        r_grant_id <= w_pick_id;
        r_grant_oh <= w_pick;
      end
      if (r_state == ST_EXEC) begin
        r_res       <= w_alu_res;
        r_flags     <= {w_alu_carry, w_alu_ovf, w_alu_zero};
        r_rsp_valid <= r_grant_oh;
      end
      if (w_rsp_done) begin
        r_rsp_valid  <= '0;
        r_last_grant <= r_grant_id;
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_res   = r_res;
  assign bus.rsp_flags = r_flags;
  assign bus.grant_id  = r_grant_id;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with two requesters; the timeout
// scenario runs only when ALU_ARB_TIMEOUT_EN is defined.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  alu_arbiter_if #(.NREQ(2)) bus ();

  alu_arbiter #(.NREQ(2), .TIMEOUT(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [2:0] op, input logic [3:0] a,
                         input logic [3:0] b);
    bus.req_op[3*idx +: 3] = op;
    bus.req_a[4*idx +: 4]  = a;
    bus.req_b[4*idx +: 4]  = b;
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '0;

    // Reset state
    step();
    step();
    check("rst_req_ready", 8'(bus.req_ready), 8'h00);
    check("rst_rsp_valid", 8'(bus.rsp_valid), 8'h00);
    check("rst_rsp_res",   8'(bus.rsp_res),   8'h00);
    check("rst_rsp_flags", 8'(bus.rsp_flags), 8'h00);
    check("rst_busy",      8'(bus.busy),      8'h00);
    check("rst_grant_id",  8'(bus.grant_id),  8'h00);
`ifdef ALU_ARB_TIMEOUT_EN
    check("rst_timeout_err", 8'(bus.timeout_err), 8'h00);
`endif
    rst = 1'b0;

    // req0 ADD 3+5 with rsp_ready held high
    bus.rsp_ready = 2'b11;
    set_req(0, ALU_ADD, 4'd3, 4'd5);
    bus.req_valid = 2'b01;
    #1;
    check("add_req_ready", 8'(bus.req_ready), 8'h01);
    step();
    bus.req_valid = 2'b00;
    check("add_exec_busy",      8'(bus.busy),      8'h01);
    check("add_exec_rsp_valid", 8'(bus.rsp_valid), 8'h00);
    check("add_exec_req_ready", 8'(bus.req_ready), 8'h00);
    step();
    check("add_rsp_valid", 8'(bus.rsp_valid), 8'h01);
    check("add_rsp_res",   8'(bus.rsp_res),   8'h08);
    check("add_rsp_flags", 8'(bus.rsp_flags), 8'h02);
    check("add_grant_id",  8'(bus.grant_id),  8'h00);
    step();
    check("add_done_rsp_valid", 8'(bus.rsp_valid), 8'h00);
    check("add_done_busy",      8'(bus.busy),      8'h00);

    // Fairness from a fresh reset: both hold valid, grants alternate 0,1,0,1
    rst = 1'b1;
    #2;
    rst = 1'b0;
    set_req(0, ALU_ADD, 4'd1, 4'd2);
    set_req(1, ALU_SUB, 4'd7, 4'd2);
    bus.req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("fair_req_ready", 8'(bus.req_ready), (k % 2 == 0) ? 8'h01 : 8'h02);
      step();
      check("fair_grant_id", 8'(bus.grant_id), 8'(k % 2));
      step();
      check("fair_rsp_valid", 8'(bus.rsp_valid), (k % 2 == 0) ? 8'h01 : 8'h02);
      check("fair_rsp_res",   8'(bus.rsp_res),   (k % 2 == 0) ? 8'h03 : 8'h05);
      step();
      if (k == 3) bus.req_valid = 2'b00;
    end

    // Backpressure on req1's response (SUB 5-5 gives zero), req0 must wait
    set_req(1, ALU_SUB, 4'd5, 4'd5);
    set_req(0, ALU_ADD, 4'd9, 4'd9);
    bus.rsp_ready = 2'b01;
    bus.req_valid = 2'b10;
    #1;
    check("bp_req_ready_1", 8'(bus.req_ready), 8'h02);
    step();
    bus.req_valid = 2'b01;
    #1;
    check("bp_exec_req_ready", 8'(bus.req_ready), 8'h00);
    step();
    check("zero_rsp_res",  8'(bus.rsp_res),      8'h00);
    check("zero_flag",     8'(bus.rsp_flags[0]), 8'h01);
    for (int i = 0; i < 10; i++) begin
      check("bp_rsp_valid", 8'(bus.rsp_valid), 8'h02);
      check("bp_rsp_res",   8'(bus.rsp_res),   8'h00);
      check("bp_busy",      8'(bus.busy),      8'h01);
      check("bp_req_ready", 8'(bus.req_ready), 8'h00);
      step();
    end
    bus.rsp_ready = 2'b11;
    #1;
    check("bp_release_req_ready", 8'(bus.req_ready), 8'h00);
    step();
    check("bp_after_rsp_valid", 8'(bus.rsp_valid), 8'h00);
    check("bp_req0_granted",    8'(bus.req_ready), 8'h01);
    step();
    bus.req_valid = 2'b00;
    step();
    check("add9_rsp_valid", 8'(bus.rsp_valid), 8'h01);
    check("add9_rsp_res",   8'(bus.rsp_res),   8'h02);
    check("add9_rsp_flags", 8'(bus.rsp_flags), 8'h06);
    step();

    // Reset during EXEC of a req1 op: outputs clear and req0 wins next
    set_req(1, ALU_OR, 4'd4, 4'd1);
    bus.req_valid = 2'b10;
    #1;
    check("rexec_req_ready", 8'(bus.req_ready), 8'h02);
    step();
    check("rexec_busy_pre", 8'(bus.busy), 8'h01);
    rst = 1'b1;
    #2;
    check("rexec_busy",      8'(bus.busy),      8'h00);
    check("rexec_rsp_valid", 8'(bus.rsp_valid), 8'h00);
    check("rexec_rsp_res",   8'(bus.rsp_res),   8'h00);
    check("rexec_rsp_flags", 8'(bus.rsp_flags), 8'h00);
    check("rexec_grant_id",  8'(bus.grant_id),  8'h00);
    rst = 1'b0;
    set_req(0, ALU_XOR, 4'd12, 4'd10);
    bus.req_valid = 2'b11;
    #1;
    check("rexec_next_pick", 8'(bus.req_ready), 8'h01);
    step();
    bus.req_valid = 2'b00;
    step();
    check("rexec_next_rsp_valid", 8'(bus.rsp_valid), 8'h01);
    check("rexec_next_rsp_res",   8'(bus.rsp_res),   8'h06);
    step();

`ifdef ALU_ARB_TIMEOUT_EN
    // Timeout: req1 response never accepted, req0 pending behind it
    bus.rsp_ready = 2'b00;
    set_req(1, ALU_ADD, 4'd2, 4'd2);
    bus.req_valid = 2'b10;
    #1;
    check("to_req_ready", 8'(bus.req_ready), 8'h02);
    step();
    bus.req_valid = 2'b01;
    step();
    check("to_rsp_valid_first", 8'(bus.rsp_valid), 8'h02);
    for (int i = 1; i < 255; i++) step();
    check("to_rsp_valid_last", 8'(bus.rsp_valid),   8'h02);
    check("to_err_before",     8'(bus.timeout_err), 8'h00);
    step();
    check("to_rsp_valid_drop", 8'(bus.rsp_valid),   8'h00);
    check("to_err_set",        8'(bus.timeout_err), 8'h01);
    check("to_next_grant",     8'(bus.req_ready),   8'h01);
    step();
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    step();
    step();
    check("to_err_sticky", 8'(bus.timeout_err), 8'h01);
    rst = 1'b1;
    #2;
    check("to_err_cleared", 8'(bus.timeout_err), 8'h00);
    rst = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares the single `alu_4bit` datapath between up to four requesters. Each requester issues an operation through a valid/ready request channel and receives the registered result and flags through a valid/ready response channel. The block sits between the requesting front-ends, such as the keyboard command path or the test harness, and the one `alu_4bit` instance. Exactly one operation is in flight at a time.

## Interface
- `NREQ`, default 2: number of requesters, legal range 2..4.
- `TIMEOUT`, default 255: response-wait limit in cycles; used only with the macro in Configuration.
- `clk`  in  1: single clock; all state is rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  NREQ: request valid, one bit per requester.
- `req_ready`  out  NREQ: one-hot grant/accept.
- `req_op`  in  3*NREQ: `alu_fnselec` code; requester i uses bits [3i+2:3i].
- `req_a`, `req_b`  in  4*NREQ: operands; requester i uses bits [4i+3:4i].
- `rsp_valid`  out  NREQ: one-hot response valid to the granted requester.
- `rsp_ready`  in  NREQ: response accept.
- `rsp_res`  out  4: registered ALU result.
- `rsp_flags`  out  3: registered {carry, overflow, zero}.
- `grant_id`  out  2: index of the current or last granted requester.
- `busy`  out  1: high in EXEC and RESP.
- `timeout_err`  out  1: sticky error flag; this port exists only with the macro.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - Pick the first i with `req_valid[i]` high, searching from `last_grant+1` modulo NREQ.
  - `req_ready` is the combinational one-hot of that pick, and is driven only in IDLE.
  - Handshake occurs when valid & ready. Op and operands latch into internal registers; `grant_id` is set to the pick; the FSM moves to EXEC.
  - No `req_valid` high: stay in IDLE with `req_ready` = 0.
- EXEC: the latched op, a and b drive `alu_4bit`. Its outputs register into `rsp_res` and `rsp_flags`. The FSM moves to RESP.
- RESP:
  - `rsp_valid[grant_id]` = 1. `rsp_res` and `rsp_flags` hold stable.
  - `rsp_ready[grant_id]` high: `last_grant` <= `grant_id`, `rsp_valid` drops, the FSM returns to IDLE.
  - `rsp_ready` from non-granted requesters is ignored.
- `req_valid` raised while busy is ignored, not queued. The requester must hold it until `req_ready` is seen.
- A requester may drop `req_valid` before being granted. It is simply skipped.
- `last_grant` resets to NREQ-1, so requester 0 wins first after reset.
- Op codes pass to `alu_4bit` unchanged. The arbiter performs no arithmetic of its own and no width conversion.
- Reset mid-operation: any in-flight result is discarded and no response is issued.
- Reset values:
  - `req_ready`, `rsp_valid`, `rsp_res`, `rsp_flags`, `busy` and `grant_id` are all 0.
  - `timeout_err` is 0 (macro builds only).

## Timing
- Request accepted in cycle T: EXEC in T+1, `rsp_valid` high from T+2.
- Minimum of 3 cycles per operation when `rsp_ready` is held high. The next grant can be given in T+3.
- `req_ready` is combinational from `req_valid` and state. All other outputs are registered.
- Requester i waits at most NREQ-1 other operations before its own grant, bounded by round-robin.

## Configuration
- `ALU_ARB_TIMEOUT_EN` defined:
  - An 8-bit wait counter runs in RESP.
  - After `TIMEOUT` cycles without `rsp_ready[grant_id]`, the FSM drops `rsp_valid`, updates `last_grant` and returns to IDLE.
  - `timeout_err` is set and stays set until `rst`.
- Macro undefined: RESP waits indefinitely, and neither the counter nor `timeout_err` exists.

## Structure
- Package `alu_arb_pkg` holds:
  - the state encoding (IDLE/EXEC/RESP);
  - the op constants `ALU_ADD`=3'b000 and `ALU_SUB`=3'b001;
  - the default `TIMEOUT`.
- Sub-module `rr_picker`: combinational round-robin one-hot select from `req_valid` and `last_grant`.
- `alu_4bit` is instantiated once, unchanged.

## Test plan
- Reset check: all outputs are 0 and the FSM is idle.
  - Stimulus: req0 ADD a=3 b=5 with `rsp_ready` held at 1.
  - Response: `req_ready[0]` in the accept cycle; `rsp_valid[0]` 2 cycles later.
  - Values: `rsp_res`=8 and `rsp_flags`={0,1,0}.
- Fairness: both requesters hold valid continuously with `rsp_ready`=11 → grants go 0,1,0,1, starting 3 cycles apart.
- Backpressure: `rsp_ready[1]`=0 for 10 cycles during req1's response → `rsp_valid[1]` and `rsp_res` stay constant, `busy`=1, and req0 is not granted until release.
- Zero flag: SUB a=5 b=5 → `rsp_res`=0 and zero flag = 1.
- Reset during EXEC: `rst` pulsed → outputs 0 immediately, no `rsp_valid`, and the next grant goes to req0.
- Timeout (macro builds): `rsp_ready` held at 0 → `rsp_valid` drops after 255 cycles in RESP, `timeout_err`=1 until reset, and the next pending requester is granted.
